pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter stage that holds the PC register, generates PC+4, and fetches instructions from instruction memory over a valid/ready request/response handshake.
- Its pc_plus4 output feeds the next-PC select mux as the sequential input. The mux result (branch/jump target) returns to this block as redirect_pc with redirect_valid as its select.
- Fetched instructions, with their PC, go to decode over a valid/ready interface.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  take redirect_pc as next fetch address
- redirect_pc  in  XLEN  redirect target from the next-PC mux
- pc_plus4  out  XLEN  current fetch PC + PC_STEP, to next-PC mux
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response data valid; one response per accepted request, in order
- imem_rsp_data  in  XLEN  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  XLEN  instruction word
- inst_pc  out  XLEN  PC of inst_data

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc = RESET_PC; state = IDLE.
  - imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
  - squash = 0, pend_valid = 0.
  - rst mid-transaction abandons everything. Any later rsp for a pre-reset request is ignored in IDLE/REQ.
- pc_plus4 = pc + PC_STEP, combinational, mod 2^XLEN (wrap at 32'hFFFF_FFFC -> 0). imem_req_addr = pc.
- States:
  - IDLE: one cycle after reset, then go to REQ.
  - REQ: imem_req_valid=1. On imem_req_ready, go to WAIT.
  - WAIT: waiting for imem_rsp_valid.
    - On rsp with squash=0: capture inst_data=rsp_data and inst_pc=pc, set inst_valid=1, go to HOLD.
    - On rsp with squash=1: drop the response, clear squash, go to REQ.
  - HOLD: inst_valid=1.
    - On inst_ready: pc <= next, inst_valid=0, go to REQ.
- Next-PC priority: pending redirect > pc_plus4.
- Handshake rules:
  - imem_req_addr stays stable while imem_req_valid && !imem_req_ready.
  - inst_data and inst_pc stay stable while inst_valid && !inst_ready.
  - At most one request outstanding.
- Minimum latency: request accepted in cycle N, rsp in N+1 -> inst_valid in N+2.
- Redirect handling:
  - Any state: a redirect is captured into pend_pc, and pend_valid is set. A later redirect overwrites it (last wins).
  - REQ: address is not changed mid-handshake. On acceptance, squash is set if pend_valid.
  - WAIT: squash is set.
  - HOLD: inst_valid drops next cycle without needing inst_ready; the instruction is discarded.
  - On leaving WAIT/HOLD toward REQ with pend_valid set: pc <= pend_pc and pend_valid is cleared.
  - IDLE: pc <= redirect_pc directly.
- Simultaneous events:
  - Redirect in the same cycle as imem_rsp_valid in WAIT: response is dropped.
  - Redirect in the same cycle as inst_ready in HOLD: the instruction counts as consumed and redirect wins as the next PC.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - Extra output misalign_fault (1 bit, reset 0).
  - A redirect_pc with bits[1:0] != 0 is not fetched. misalign_fault is set and held, and state parks in IDLE until rst.
  - The faulting address is available on inst_pc with inst_valid=0.
- Without the macro: redirect_pc[1:0] is forced to 2'b00 and there is no fault port.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE, REQ, WAIT, HOLD).
  - XLEN and RESET_PC defaults.
  - PC_STEP constant.
- One natural sub-module, pc_redirect_buf: holds the pend_valid/pend_pc register with last-wins overwrite and clear-on-consume.

Test Plan:
- Reset sequence: rst=1 for 2 cycles, then release.
  - Required: req_addr=0 one cycle after IDLE.
  - With ready=1 and rsp next cycle holding 32'h0000_0013: inst_valid=1, inst_pc=0, pc_plus4=4.
- Streaming with inst_ready=1 and zero-wait memory:
  - Required: inst_pc sequence 0, 4, 8, 12, one instruction every 3 cycles.
- Backpressure: imem_req_ready=0 for 5 cycles.
  - Required: req_addr held at 8.
  - Then inst_ready=0 for 4 cycles; required: inst_data and inst_pc unchanged.
- Redirect to 0x100 while in WAIT:
  - Required: response dropped, no inst_valid for the old PC.
  - Next req_addr=0x100, next inst_pc=0x100.
- Two redirects, 0x200 then 0x300, during one REQ stall:
  - Required: after the in-flight response is squashed, req_addr=0x300.
- RESET_PC=32'hFFFF_FFFC:
  - Required: pc_plus4=0 and the second fetch address is 0.
  - With the macro defined: redirect_pc=0x102 -> misalign_fault=1 and no further requests.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, PC step and fetch FSM states
package fetch_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - pending redirect register, last write wins, cleared on consume
module pc_redirect_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic [XLEN-1:0] set_pc,
    input  logic            clr,
    output logic            pend_valid,
    output logic [XLEN-1:0] pend_pc
);

    // A new redirect always overrides both an older one and a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (set) begin
            pend_valid <= 1'b1;
            pend_pc    <= set_pc;
        end else if (clr) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction fetch FSM; optional PC_FETCH_MISALIGN_CHECK_EN
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              PC_STEP  = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    output logic            misalign_fault,
`endif
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            squash;
    logic            pend_valid;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] rpc;
    logic            fault_hit;
    logic            fault_q;
    logic            redir;
    logic            take;
    logic [XLEN-1:0] take_pc;
    logic            buf_set;
    logic            buf_clr;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    assign rpc       = redirect_pc;
    assign fault_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (fault_hit) begin
            fault_q <= 1'b1;
        end
    end

    assign misalign_fault = fault_q;
`else
    assign rpc       = redirect_pc & ALIGN_MASK;
    assign fault_hit = 1'b0;
    assign fault_q   = 1'b0;
`endif

    assign redir          = redirect_valid && !fault_hit;
    assign pc_plus4       = pc + XLEN'(PC_STEP);
    assign imem_req_addr  = pc;
    assign imem_req_valid = (state == ST_REQ);
    assign inst_valid     = (state == ST_HOLD);

    // Decide whether this cycle leaves WAIT/HOLD for a fresh request, and from where.
    always_comb begin
        take = 1'b0;
        case (state)
            ST_WAIT: take = imem_rsp_valid && (squash || redir);
            ST_HOLD: take = redir || pend_valid || inst_ready;
            default: take = 1'b0;
        endcase
        if (redir) begin
            take_pc = rpc;
        end else if (pend_valid) begin
            take_pc = pend_pc;
        end else begin
            take_pc = pc_plus4;
        end
    end

    // A redirect used directly this cycle never needs to be buffered.
    assign buf_set = redir && !take && (state != ST_IDLE);
    assign buf_clr = take || (state == ST_IDLE);

    pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .set        (buf_set),
        .set_pc     (rpc),
        .clr        (buf_clr),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc)
    );

    // Fetch FSM, PC register and decode-side instruction holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            squash    <= 1'b0;
            inst_data <= '0;
            inst_pc   <= '0;
        end else if (fault_hit || fault_q) begin
            state  <= ST_IDLE;
            squash <= 1'b0;
            if (fault_hit) begin
                inst_pc <= redirect_pc;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redir) begin
                        pc <= rpc;
                    end
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        squash <= pend_valid || redir;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (take) begin
                        squash <= 1'b0;
                        pc     <= take_pc;
                        state  <= ST_REQ;
                    end else if (imem_rsp_valid) begin
                        inst_data <= imem_rsp_data;
                        inst_pc   <= pc;
                        state     <= ST_HOLD;
                    end else if (redir) begin
                        squash <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (take) begin
                        pc    <= take_pc;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized bench with program-order fetch model; optional PC_FETCH_MISALIGN_CHECK_EN
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
    localparam logic [31:0] TMASK = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] TMASK = 32'hFFFF_FFFF;
`endif

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_plus4       (pc_plus4),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        .misalign_fault (misalign_fault),
`endif
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int rdy_pct, irdy_pct, redir_pm, min_dly, max_dly;
    logic        force_redir;
    logic [31:0] force_target;

    logic        mem_pend;
    int          mem_dly;
    logic [31:0] mem_addr;

    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    int          n_cons;
    int          cyc;
    int          cons_cyc[$];

    logic        prev_req_stall;
    logic [31:0] prev_addr;
    logic        prev_inst_stall;
    logic [31:0] prev_ipc;
    logic [31:0] prev_idata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock: memory model, random inputs, program-order checks, then the edge.
    task automatic step();
        imem_rsp_valid = 1'b0;
        if (mem_pend) begin
            if (mem_dly == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 1'b0;
            end else begin
                mem_dly--;
            end
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
        redirect_pc    = force_redir ? force_target : ($urandom & TMASK);
        force_redir    = 1'b0;

        if (prev_req_stall) begin
            check_eq("req_hold_valid", imem_req_valid, 1);
            check_eq("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (prev_inst_stall) begin
            check_eq("inst_hold_valid", inst_valid, 1);
            check_eq("inst_hold_pc", inst_pc, prev_ipc);
            check_eq("inst_hold_data", inst_data, prev_idata);
        end
        prev_req_stall  = imem_req_valid && !imem_req_ready;
        prev_addr       = imem_req_addr;
        prev_inst_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_ipc        = inst_pc;
        prev_idata      = inst_data;

        if (imem_req_valid && imem_req_ready) begin
            check_eq("one_outstanding", mem_pend, 0);
            mem_pend = 1'b1;
            mem_addr = imem_req_addr;
            mem_dly  = $urandom_range(max_dly, min_dly);
        end

        if (inst_valid && inst_ready) begin
            check_eq("inst_pc_order", inst_pc, exp_pc);
            check_eq("inst_data_mem", inst_data, mem_word(inst_pc));
            last_pc = inst_pc;
            exp_pc  = exp_pc + 32'd4;
            n_cons++;
            cons_cyc.push_back(cyc);
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int k;
        int n0;
        logic ok;

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        inst_ready = 1'b0;
        force_redir = 1'b0;
        force_target = '0;
        mem_pend = 1'b0;
        mem_dly = 0;
        mem_addr = '0;
        exp_pc = 32'h0;
        last_pc = '0;
        n_cons = 0;
        cyc = 0;
        prev_req_stall = 1'b0;
        prev_inst_stall = 1'b0;
        prev_addr = '0;
        prev_ipc = '0;
        prev_idata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_inst_data", inst_data, 0);
        check_eq("rst_pc_plus4", pc_plus4, 32'd4);
        check_eq("rst_req_addr", imem_req_addr, 0);
        rst = 1'b0;

        // First fetch at minimum latency, then streaming
        rdy_pct = 100; irdy_pct = 100; redir_pm = 0; min_dly = 0; max_dly = 0;
        step();
        check_eq("first_req_valid", imem_req_valid, 1);
        check_eq("first_req_addr", imem_req_addr, 0);
        step();
        check_eq("wait_no_inst", inst_valid, 0);
        step();
        check_eq("first_inst_valid", inst_valid, 1);
        check_eq("first_inst_pc", inst_pc, 0);
        check_eq("first_inst_data", inst_data, 32'h0000_0013);
        check_eq("first_pc_plus4", pc_plus4, 32'd4);
        for (k = 0; k < 40 && cons_cyc.size() < 4; k++) step();
        check_eq("stream_count", 32'(cons_cyc.size() >= 4), 1);
        if (cons_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                check_eq("stream_spacing", 32'(cons_cyc[i] - cons_cyc[i-1]), 3);
        end

        // Backpressure on both sides
        rdy_pct = 0; irdy_pct = 0;
        repeat (6) step();
        rdy_pct = 100;
        repeat (6) step();
        irdy_pct = 100;
        repeat (3) step();

        // Redirect to 0x100 while a request is in flight
        min_dly = 2; max_dly = 2;
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin step(); ok = mem_pend; end
        check_eq("reach_wait", ok, 1);
        force_redir = 1'b1; force_target = 32'h100;
        step();
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin step(); ok = imem_req_valid; end
        check_eq("redir_req_seen", ok, 1);
        check_eq("redir_req_addr", imem_req_addr, 32'h100);
        n0 = n_cons;
        for (k = 0; k < 20 && n_cons == n0; k++) step();
        check_eq("redir_inst_pc", last_pc, 32'h100);

        // Two redirects during one request stall, last one wins
        min_dly = 0; max_dly = 0; rdy_pct = 0;
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin step(); ok = imem_req_valid; end
        force_redir = 1'b1; force_target = 32'h200;
        step();
        force_redir = 1'b1; force_target = 32'h300;
        step();
        repeat (3) step();
        rdy_pct = 100;
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin step(); ok = mem_pend; end
        ok = 1'b0;
        for (k = 0; k < 20 && !ok; k++) begin step(); ok = imem_req_valid; end
        check_eq("two_redir_seen", ok, 1);
        check_eq("two_redir_addr", imem_req_addr, 32'h300);

        // PC wrap at the top of the address space
        force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
        step();
        ok = 1'b0;
        for (k = 0; k < 30 && !ok; k++) begin
            step();
            ok = imem_req_valid && (imem_req_addr == 32'hFFFF_FFFC);
        end
        check_eq("wrap_req_seen", ok, 1);
        check_eq("wrap_pc_plus4", pc_plus4, 0);
        ok = 1'b0;
        for (k = 0; k < 30 && !ok; k++) begin
            step();
            ok = imem_req_valid && (imem_req_addr != 32'hFFFF_FFFC);
        end
        check_eq("wrap_next_addr", imem_req_addr, 0);

        // Random traffic
        rdy_pct = 70; irdy_pct = 70; redir_pm = 40; min_dly = 0; max_dly = 3;
        n0 = n_cons;
        repeat (3000) step();
        check_eq("progress", 32'((n_cons - n0) > 100), 1);

`ifdef PC_FETCH_MISALIGN_CHECK_EN
        redir_pm = 0; rdy_pct = 100;
        force_redir = 1'b1; force_target = 32'h102;
        step();
        check_eq("fault_set", misalign_fault, 1);
        check_eq("fault_inst_pc", inst_pc, 32'h102);
        check_eq("fault_inst_valid", inst_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("fault_no_req", imem_req_valid, 0);
            check_eq("fault_held", misalign_fault, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
